// File: rtl/op_sweep_pkg.sv
// Shared types and default widths for the opcode sweep controller.
package op_sweep_pkg;

    localparam int unsigned DW_DEF       = 4;
    localparam int unsigned NW_DEF       = 3;
    localparam int unsigned OP_COUNT_DEF = 8;
    localparam int unsigned CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CAPTURE,
        DONE
    } sweep_state_e;

endpackage

// File: rtl/next_set_bit.sv
// Finds the lowest set mask bit, either overall (first=1) or strictly above idx.
module next_set_bit
    import op_sweep_pkg::*;
#(
    parameter int unsigned NW       = NW_DEF,
    parameter int unsigned OP_COUNT = OP_COUNT_DEF
) (
    input  logic [OP_COUNT-1:0] mask,
    input  logic [NW-1:0]       idx,
    input  logic                first,
    output logic [NW-1:0]       nxt,
    output logic                found
);

    // Scan downward so the lowest qualifying bit is the last one written.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = int'(OP_COUNT) - 1; i >= 0; i--) begin
            if (mask[i] && (first || (NW'(i) > idx))) begin
                nxt   = NW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/op_sweep_ctrl.sv
// Opcode sweep driver: latches A/B and a mask, steps N through enabled opcodes,
// returns {op, X} on a valid/ready stream. Define OP_SWEEP_CHECKSUM_EN to build the chk XOR register.
module op_sweep_ctrl
    import op_sweep_pkg::*;
#(
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned NW       = NW_DEF,
    parameter int unsigned SETTLE   = 1,
    localparam int unsigned OP_COUNT = 2 ** NW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [DW-1:0]       a_in,
    input  logic [DW-1:0]       b_in,
    input  logic [OP_COUNT-1:0] op_mask,
    output logic [DW-1:0]       A,
    output logic [DW-1:0]       B,
    output logic [NW-1:0]       N,
    input  logic [DW-1:0]       X,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [NW-1:0]       res_op,
    output logic [DW-1:0]       res_data,
    output logic                busy,
    output logic                done,
    output logic [DW-1:0]       chk
);

    sweep_state_e         state_q, state_d;
    logic [DW-1:0]        a_q, a_d, b_q, b_d, rdat_q, rdat_d;
    logic [NW-1:0]        n_q, n_d, idx_q, idx_d, rop_q, rop_d;
    logic [OP_COUNT-1:0]  mask_q, mask_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rv_q, rv_d, busy_q, busy_d, done_q, done_d;

    logic                 nsb_first, nsb_found;
    logic [OP_COUNT-1:0]  nsb_mask;
    logic [NW-1:0]        nsb_nxt;
    logic                 launch, accept;

    assign nsb_first = (state_q == IDLE);
    assign nsb_mask  = nsb_first ? op_mask : mask_q;
    assign launch    = (state_q == IDLE) && start && !abort;
    assign accept    = (state_q == CAPTURE) && rv_q && res_ready && !abort;

    next_set_bit #(.NW(NW), .OP_COUNT(OP_COUNT)) u_nsb (
        .mask  (nsb_mask),
        .idx   (idx_q),
        .first (nsb_first),
        .nxt   (nsb_nxt),
        .found (nsb_found)
    );

    // Next-state and next-output logic; N is driven in the first APPLY cycle, X sampled after SETTLE cycles.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rv_d    = rv_q;
        rop_d   = rop_q;
        rdat_d  = rdat_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    a_d    = a_in;
                    b_d    = b_in;
                    mask_d = op_mask;
                    if (nsb_found) begin
                        idx_d   = nsb_nxt;
                        cnt_d   = CNT_W'(SETTLE);
                        state_d = APPLY;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            APPLY: begin
                n_d = idx_q;
                if (cnt_q == '0) begin
                    rdat_d  = X;
                    rop_d   = idx_q;
                    rv_d    = 1'b1;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CAPTURE: begin
                if (rv_q && res_ready) begin
                    rv_d = 1'b0;
                    if (nsb_found) begin
                        idx_d   = nsb_nxt;
                        cnt_d   = CNT_W'(SETTLE);
                        state_d = APPLY;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort cancels without a done pulse; mux inputs stay where they were.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            rv_d    = 1'b0;
            done_d  = 1'b0;
            n_d     = n_q;
            idx_d   = idx_q;
            cnt_d   = cnt_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            rv_q    <= 1'b0;
            rop_q   <= '0;
            rdat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rv_q    <= rv_d;
            rop_q   <= rop_d;
            rdat_q  <= rdat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef OP_SWEEP_CHECKSUM_EN
    logic [DW-1:0] chk_q;

    // Running XOR of accepted results; cleared only by a new sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= '0;
        end else if (launch) begin
            chk_q <= '0;
        end else if (accept) begin
            chk_q <= chk_q ^ rdat_q;
        end
    end

    assign chk = chk_q;
`else
    assign chk = '0;
`endif

    assign A         = a_q;
    assign B         = b_q;
    assign N         = n_q;
    assign res_valid = rv_q;
    assign res_op    = rop_q;
    assign res_data  = rdat_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_op_sweep_ctrl.sv
// Self-checking bench for op_sweep_ctrl with an attached opcode-mux model.
module tb_op_sweep_ctrl;

    localparam int unsigned DW     = 4;
    localparam int unsigned NW     = 3;
    localparam int unsigned OPC    = 8;
    localparam int unsigned SETTLE = 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [DW-1:0]  a_in = '0;
    logic [DW-1:0]  b_in = '0;
    logic [OPC-1:0] op_mask = '0;
    logic           res_ready = 1'b0;
    logic [DW-1:0]  A, B, X, res_data, chk;
    logic [NW-1:0]  N, res_op;
    logic           res_valid, busy, done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    op_sweep_ctrl #(.DW(DW), .NW(NW), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a_in(a_in), .b_in(b_in), .op_mask(op_mask),
        .A(A), .B(B), .N(N), .X(X),
        .res_valid(res_valid), .res_ready(res_ready), .res_op(res_op), .res_data(res_data),
        .busy(busy), .done(done), .chk(chk)
    );

    // Behavioural 4-bit opcode mux the controller drives.
    function automatic logic [DW-1:0] mux_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [NW-1:0] n);
        case (n)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return {a[DW-2:0], 1'b0};
            default: return b;
        endcase
    endfunction

    assign X = mux_f(A, B, N);

    // j-th enabled opcode in ascending order, -1 if fewer are enabled.
    function automatic int nth_op(input logic [OPC-1:0] m, input int j);
        int c = 0;
        for (int k = 0; k < int'(OPC); k++) begin
            if (m[k]) begin
                if (c == j) return k;
                c++;
            end
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] exp_chk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [OPC-1:0] m);
        logic [DW-1:0] x = '0;
        for (int k = 0; k < int'(OPC); k++)
            if (m[k]) x = x ^ mux_f(a, b, NW'(k));
        return x;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records handshakes, valid rises, done pulses and busy cycles.
    logic [NW-1:0] got_op[$];
    logic [DW-1:0] got_dat[$];
    int            got_cyc[$];
    int            rise_cyc[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            busy_cnt = 0;
    logic          prev_rv = 1'b0;

    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            got_op.push_back(res_op);
            got_dat.push_back(res_data);
            got_cyc.push_back(cyc);
        end
        if (res_valid && !prev_rv) rise_cyc.push_back(cyc);
        prev_rv <= res_valid;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [OPC-1:0] m, output int s_edge);
        a_in = a; b_in = b; op_mask = m; start = 1'b1;
        step();
        start = 1'b0;
        s_edge = cyc;
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > base) break;
            step();
        end
        ok = (done_cnt > base);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_cmp++; if ({A, B, N} !== '0) begin n_err++; $display("FAIL reset_abn got %h want 0", {A, B, N}); end
        n_cmp++; if ({res_valid, res_op, res_data} !== '0) begin n_err++; $display("FAIL reset_res got %h want 0", {res_valid, res_op, res_data}); end
        n_cmp++; if ({busy, done, chk} !== '0) begin n_err++; $display("FAIL reset_ctl got %h want 0", {busy, done, chk}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sweep_basic();
        int s, hb, rb, db, n; bit ok;
        hb = got_op.size(); rb = rise_cyc.size(); db = done_cnt;
        res_ready = 1'b1;
        do_start(4'b0110, 4'b0101, 8'h0F, s);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy got %b want 1", busy); end
        wait_done(db, 60, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL t1_done_timeout got 0 want 1"); end
        n = got_op.size() - hb;
        n_cmp++; if (n != 4) begin n_err++; $display("FAIL t1_count got %0d want 4", n); end
        for (int j = 0; j < n && j < 4; j++) begin
            n_cmp++; if (got_op[hb+j] !== NW'(j)) begin n_err++; $display("FAIL t1_op%0d got %0d want %0d", j, got_op[hb+j], j); end
            n_cmp++; if (got_dat[hb+j] !== mux_f(4'b0110, 4'b0101, NW'(j))) begin n_err++;
                $display("FAIL t1_data%0d got %h want %h", j, got_dat[hb+j], mux_f(4'b0110, 4'b0101, NW'(j))); end
        end
        if (rise_cyc.size() >= rb + 2 && n >= 1) begin
            n_cmp++; if (rise_cyc[rb] != s + int'(SETTLE) + 1) begin n_err++; $display("FAIL t1_first_latency got %0d want %0d", rise_cyc[rb] - s, SETTLE + 1); end
            n_cmp++; if (rise_cyc[rb+1] != got_cyc[hb] + int'(SETTLE) + 2) begin n_err++;
                $display("FAIL t1_next_latency got %0d want %0d", rise_cyc[rb+1] - got_cyc[hb] - 1, SETTLE + 1); end
        end
        if (n == 4) begin
            n_cmp++; if (done_cyc != got_cyc[hb+3] + 2) begin n_err++; $display("FAIL t1_done_time got %0d want %0d", done_cyc, got_cyc[hb+3] + 2); end
        end
        step(); step();
        n_cmp++; if (done_cnt - db != 1) begin n_err++; $display("FAIL t1_done_width got %0d want 1", done_cnt - db); end
        n_cmp++; if ({A, B, N} !== {4'b0110, 4'b0101, 3'd3}) begin n_err++; $display("FAIL t1_hold got %h want %h", {A, B, N}, {4'b0110, 4'b0101, 3'd3}); end
    endtask

    task automatic test_sparse_mask();
        int s, hb, db, n; bit ok;
        logic [DW-1:0] a, b;
        a = DW'($urandom); b = DW'($urandom);
        hb = got_op.size(); db = done_cnt;
        res_ready = 1'b1;
        do_start(a, b, 8'b0100_1000, s);
        wait_done(db, 60, ok);
        n = got_op.size() - hb;
        n_cmp++; if (!ok || n != 2) begin n_err++; $display("FAIL t2_count got %0d done %b want 2", n, ok); end
        for (int j = 0; j < n && j < 2; j++) begin
            n_cmp++; if ({got_op[hb+j], got_dat[hb+j]} !== {NW'(nth_op(8'h48, j)), mux_f(a, b, NW'(nth_op(8'h48, j)))}) begin n_err++;
                $display("FAIL t2_res%0d got %0d/%h want %0d/%h", j, got_op[hb+j], got_dat[hb+j], nth_op(8'h48, j), mux_f(a, b, NW'(nth_op(8'h48, j)))); end
        end
    endtask

    task automatic test_empty_mask();
        int s, rb, db, bb; bit ok;
        rb = rise_cyc.size(); db = done_cnt; bb = busy_cnt;
        do_start(DW'($urandom), DW'($urandom), 8'h00, s);
        wait_done(db, 10, ok);
        step(); step();
        n_cmp++; if (!ok || done_cyc != s + 1) begin n_err++; $display("FAIL t3_done_time got %0d want %0d", done_cyc - s, 1); end
        n_cmp++; if (rise_cyc.size() != rb) begin n_err++; $display("FAIL t3_no_valid got %0d want 0", rise_cyc.size() - rb); end
        n_cmp++; if (busy_cnt - bb != 1) begin n_err++; $display("FAIL t3_busy_cycles got %0d want 1", busy_cnt - bb); end
    endtask

    task automatic test_backpressure();
        int s, hb, db, n; bit ok;
        logic [DW-1:0] a, b;
        a = DW'($urandom); b = DW'($urandom);
        hb = got_op.size(); db = done_cnt;
        res_ready = 1'b0;
        do_start(a, b, 8'h0F, s);
        for (int i = 0; i < 20 && !res_valid; i++) step();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        for (int i = 0; i < 20 && !res_valid; i++) step();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({res_valid, res_op, res_data, N} !== {1'b1, 3'd1, mux_f(a, b, 3'd1), 3'd1}) begin n_err++;
                $display("FAIL t4_hold%0d got %h want %h", i, {res_valid, res_op, res_data, N}, {1'b1, 3'd1, mux_f(a, b, 3'd1), 3'd1}); end
            step();
        end
        res_ready = 1'b1;
        wait_done(db, 60, ok);
        n = got_op.size() - hb;
        n_cmp++; if (!ok || n != 4) begin n_err++; $display("FAIL t4_count got %0d want 4", n); end
        for (int j = 0; j < n && j < 4; j++) begin
            n_cmp++; if (got_op[hb+j] !== NW'(j)) begin n_err++; $display("FAIL t4_order%0d got %0d want %0d", j, got_op[hb+j], j); end
        end
    endtask

    task automatic test_abort_reset();
        int s, hb, db, n; bit ok;
        logic [DW-1:0] a, b;
        a = DW'($urandom); b = DW'($urandom);
        hb = got_op.size(); db = done_cnt;
        res_ready = 1'b1;
        do_start(a, b, 8'hFF, s);
        for (int i = 0; i < 30 && !(N == 3'd2 && busy && !res_valid && got_op.size() - hb >= 2); i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++; if ({busy, res_valid} !== 2'b00) begin n_err++; $display("FAIL t5_abort_idle got %b want 00", {busy, res_valid}); end
        n_cmp++; if ({A, B, N} !== {a, b, 3'd2}) begin n_err++; $display("FAIL t5_abort_hold got %h want %h", {A, B, N}, {a, b, 3'd2}); end
        step(); step(); step();
        n_cmp++; if (done_cnt != db) begin n_err++; $display("FAIL t5_no_done got %0d want 0", done_cnt - db); end
        n_cmp++; if (got_op.size() - hb != 2) begin n_err++; $display("FAIL t5_abort_count got %0d want 2", got_op.size() - hb); end

        do_start(~a, ~b, 8'hFF, s);
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({A, B, N, res_valid, res_op, res_data, busy, done, chk} !== '0) begin n_err++;
            $display("FAIL t5_async_reset got %h want 0", {A, B, N, res_valid, res_op, res_data, busy, done, chk}); end
        @(negedge clk);
        rst_n = 1'b1;
        step();

        hb = got_op.size(); db = done_cnt;
        do_start(a, b, 8'h80, s);
        wait_done(db, 30, ok);
        n = got_op.size() - hb;
        n_cmp++; if (!ok || n != 1) begin n_err++; $display("FAIL t5_op7_count got %0d want 1", n); end
        if (n >= 1) begin
            n_cmp++; if ({got_op[hb], got_dat[hb]} !== {3'd7, mux_f(a, b, 3'd7)}) begin n_err++;
                $display("FAIL t5_op7 got %0d/%h want 7/%h", got_op[hb], got_dat[hb], mux_f(a, b, 3'd7)); end
        end
    endtask

    task automatic test_start_rules();
        int s, hb, db, n; bit ok;
        logic [DW-1:0] a, b;
        a = DW'($urandom); b = DW'($urandom);
        hb = got_op.size(); db = done_cnt;
        res_ready = 1'b0;
        do_start(a, b, 8'h03, s);
        step();
        a_in = ~a; b_in = ~b; op_mask = 8'h80; start = 1'b1;
        step();
        start = 1'b0;
        res_ready = 1'b1;
        wait_done(db, 40, ok);
        n = got_op.size() - hb;
        n_cmp++; if (!ok || n != 2) begin n_err++; $display("FAIL busy_start_count got %0d want 2", n); end
        for (int j = 0; j < n && j < 2; j++) begin
            n_cmp++; if ({got_op[hb+j], got_dat[hb+j]} !== {NW'(j), mux_f(a, b, NW'(j))}) begin n_err++;
                $display("FAIL busy_start_res%0d got %0d/%h want %0d/%h", j, got_op[hb+j], got_dat[hb+j], j, mux_f(a, b, NW'(j))); end
        end
        step();
        a_in = ~a; op_mask = 8'hFF; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        n_cmp++; if ({busy, A} !== {1'b0, a}) begin n_err++; $display("FAIL start_abort_idle got %h want %h", {busy, A}, {1'b0, a}); end
    endtask

    task automatic test_checksum();
        int s, db; bit ok;
        logic [DW-1:0] want;
`ifdef OP_SWEEP_CHECKSUM_EN
        want = exp_chk(4'b0110, 4'b0101, 8'h4F);
`else
        want = '0;
`endif
        db = done_cnt;
        res_ready = 1'b1;
        do_start(4'b0110, 4'b0101, 8'h4F, s);
        n_cmp++; if (chk !== '0) begin n_err++; $display("FAIL t6_chk_clear got %h want 0", chk); end
        wait_done(db, 60, ok);
        n_cmp++; if (!ok || chk !== want) begin n_err++; $display("FAIL t6_chk_done got %h want %h", chk, want); end
        step(); step(); step();
        n_cmp++; if (chk !== want) begin n_err++; $display("FAIL t6_chk_hold got %h want %h", chk, want); end
    endtask

    task automatic test_random();
        int s, hb, db, n, want_n; bit ok;
        logic [DW-1:0] a, b;
        logic [OPC-1:0] m;
        for (int it = 0; it < 8; it++) begin
            a = DW'($urandom); b = DW'($urandom); m = OPC'($urandom);
            hb = got_op.size(); db = done_cnt;
            res_ready = 1'($urandom);
            do_start(a, b, m, s);
            for (int i = 0; i < 200 && done_cnt == db; i++) begin
                res_ready = 1'($urandom);
                step();
            end
            ok = (done_cnt > db);
            n = got_op.size() - hb;
            want_n = $countones(m);
            n_cmp++; if (!ok || n != want_n) begin n_err++; $display("FAIL rnd%0d_count got %0d want %0d mask %h", it, n, want_n, m); end
            for (int j = 0; j < n && j < want_n; j++) begin
                n_cmp++; if ({got_op[hb+j], got_dat[hb+j]} !== {NW'(nth_op(m, j)), mux_f(a, b, NW'(nth_op(m, j)))}) begin n_err++;
                    $display("FAIL rnd%0d_res%0d got %0d/%h want %0d/%h", it, j, got_op[hb+j], got_dat[hb+j], nth_op(m, j), mux_f(a, b, NW'(nth_op(m, j)))); end
            end
`ifdef OP_SWEEP_CHECKSUM_EN
            n_cmp++; if (chk !== exp_chk(a, b, m)) begin n_err++; $display("FAIL rnd%0d_chk got %h want %h", it, chk, exp_chk(a, b, m)); end
`else
            n_cmp++; if (chk !== '0) begin n_err++; $display("FAIL rnd%0d_chk got %h want 0", it, chk); end
`endif
            step();
        end
    endtask

    initial begin
        test_reset();
        test_sweep_basic();
        test_sparse_mask();
        test_empty_mask();
        test_backpressure();
        test_abort_reset();
        test_start_rules();
        test_checksum();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
